// File: rtl/rfm_pend_tracker_pkg.sv
// Shared constants and FSM state encoding for the RFM pending-row tracker.
// Optional feature macro used by the tracker files: RFM_PEND_CNT_EN.
package rfm_pkg;
  localparam int RFM_N      = 1024;
  localparam int RFM_LOG2N  = 10;
  localparam int RFM_PE_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    WAIT  = 2'd2
  } rfm_state_e;
endpackage

// File: rtl/rfm_pend_tracker_if.sv
// Bus bundle between the tracker, its row source, the priority encoder and the issuer.
// slave = tracker side, master = everything around it.
interface rfm_pend_tracker_if
  import rfm_pkg::*;
#(
  parameter int N     = RFM_N,
  parameter int LOG2N = RFM_LOG2N
) ();
  logic             set_vld;
  logic [LOG2N-1:0] set_idx;
  logic             flush;
  logic [N-1:0]     pe_oht;
  logic [LOG2N-1:0] pe_bin;
  logic             pe_vld;
  logic             iss_vld;
  logic [LOG2N-1:0] iss_idx;
  logic             iss_rdy;
  logic             dup;
  logic [LOG2N:0]   pend_cnt;

  modport slave (
    input  set_vld, set_idx, flush, pe_bin, pe_vld, iss_rdy,
    output pe_oht, iss_vld, iss_idx, dup, pend_cnt
  );

  modport master (
    output set_vld, set_idx, flush, pe_bin, pe_vld, iss_rdy,
    input  pe_oht, iss_vld, iss_idx, dup, pend_cnt
  );
endinterface

// File: rtl/rfm_pend_tracker_pend_vec.sv
// N-bit pending-row register with set/clear/flush; set beats a same-row clear, flush beats both.
// With RFM_PEND_CNT_EN defined it also emits the registered dup pulse and count deltas.
module rfm_pend_vec
  import rfm_pkg::*;
#(
  parameter int N     = RFM_N,
  parameter int LOG2N = RFM_LOG2N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_set_vld,
  input  logic [LOG2N-1:0] i_set_idx,
  input  logic             i_clr_vld,
  input  logic [LOG2N-1:0] i_clr_idx,
  input  logic             i_flush,
  output logic [N-1:0]     o_pend
`ifdef RFM_PEND_CNT_EN
  ,
  output logic             o_dup,
  output logic             o_inc,
  output logic             o_dec
`endif
);
  logic [N-1:0] r_pend;
  logic [N-1:0] w_pend_next;

  always_comb begin
    w_pend_next = r_pend;
    if (i_clr_vld) w_pend_next[i_clr_idx] = 1'b0;
    if (i_set_vld) w_pend_next[i_set_idx] = 1'b1;
    if (i_flush)   w_pend_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_pend <= '0;
    else      r_pend <= w_pend_next;
  end

  assign o_pend = r_pend;

`ifdef RFM_PEND_CNT_EN
  logic w_hit;
  logic r_dup;

  assign w_hit = r_pend[i_set_idx];
  assign o_inc = i_set_vld && !w_hit;
  // A fire on a row that is re-set in the same cycle leaves the row pending.
  assign o_dec = i_clr_vld && !(i_set_vld && (i_set_idx == i_clr_idx));

  always_ff @(posedge clk) begin
    if (!rst) r_dup <= 1'b0;
    else      r_dup <= i_set_vld && w_hit && !i_flush;
  end

  assign o_dup = r_dup;
`endif
endmodule

// File: rtl/rfm_pend_tracker.sv
// Pending-row tracker around the priority encoder: offers encoder picks to the RFM issuer.
// Define RFM_PEND_CNT_EN to build the pend_cnt counter and dup pulse; otherwise both read 0.
module rfm_pend_tracker
  import rfm_pkg::*;
#(
  parameter int N      = RFM_N,
  parameter int LOG2N  = RFM_LOG2N,
  parameter int PE_LAT = RFM_PE_LAT
) (
  input logic               clk,
  input logic               rst,
  rfm_pend_tracker_if.slave bus
);
  localparam int WCNT_W = (PE_LAT > 1) ? $clog2(PE_LAT + 1) : 1;

  rfm_state_e        r_state, w_state_next;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_next;
  logic [N-1:0]      w_pend;
  logic              w_iss_vld;
  logic              w_fire;
  logic              w_any;

  // Gating on the live pend bit hides encoder results that lag a clear.
  assign w_iss_vld   = rst && (r_state == OFFER) && bus.pe_vld && w_pend[bus.pe_bin];
  assign w_fire      = w_iss_vld && bus.iss_rdy;
  assign bus.iss_vld = w_iss_vld;
  assign bus.iss_idx = bus.pe_bin;
  assign bus.pe_oht  = w_pend;

`ifdef RFM_PEND_CNT_EN
  logic [LOG2N:0] r_cnt, w_cnt_next;
  logic           w_inc;
  logic           w_dec;

  always_comb begin
    w_cnt_next = r_cnt;
    if (bus.flush)
      w_cnt_next = '0;
    else if (w_inc && !w_dec && (r_cnt != (LOG2N+1)'(N)))
      w_cnt_next = r_cnt + 1'b1;
    else if (w_dec && !w_inc)
      w_cnt_next = r_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_cnt_next;
  end

  assign w_any        = (r_cnt != '0);
  assign bus.pend_cnt = r_cnt;
`else
  assign w_any        = |w_pend;
  assign bus.pend_cnt = '0;
  assign bus.dup      = 1'b0;
`endif

  rfm_pend_vec #(.N(N), .LOG2N(LOG2N)) u_pend_vec (
    .clk       (clk),
    .rst       (rst),
    .i_set_vld (bus.set_vld),
    .i_set_idx (bus.set_idx),
    .i_clr_vld (w_fire),
    .i_clr_idx (bus.pe_bin),
    .i_flush   (bus.flush),
    .o_pend    (w_pend)
`ifdef RFM_PEND_CNT_EN
    ,
    .o_dup     (bus.dup),
    .o_inc     (w_inc),
    .o_dec     (w_dec)
`endif
  );

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_next = OFFER;
      end
      OFFER: begin
        if (w_fire) begin
          w_state_next = WAIT;
          w_wcnt_next  = WCNT_W'(PE_LAT);
        end
      end
      WAIT: begin
        // Hold off until the encoder has seen the cleared bit.
        w_wcnt_next = r_wcnt - 1'b1;
        if (r_wcnt <= WCNT_W'(1)) w_state_next = w_any ? OFFER : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (bus.flush) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end
endmodule

// File: doc/rfm_pend_tracker.md
Name: rfm_pend_tracker

Overview:
- Owns the 1024-entry pending-row vector that drives the 1024-wide priority encoder (oht input).
- Consumes the encoder's bin/vld result and offers the selected row index to the RFM command issuer over a valid/ready handshake.
- Clears each issued row and masks stale encoder results caused by the encoder's pipeline register.
- Sits directly around the encoder: upstream (vector source) and downstream (result consumer) in one stage.

Parameters:
- N, 1024, number of tracked rows; must equal encoder width.
- LOG2N, 10, index width.
- PE_LAT, 1, cycles from an oht change to the matching bin/vld change at the encoder output.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- set_vld  in  1  mark row set_idx pending
- set_idx  in  LOG2N  row to mark
- flush  in  1  clear all pending rows
- pe_oht  out  N  pending vector, to encoder oht
- pe_bin  in  LOG2N  encoder index
- pe_vld  in  1  encoder valid
- iss_vld  out  1  row offered to issuer
- iss_idx  out  LOG2N  offered row
- iss_rdy  in  1  issuer accepts
- dup  out  1  one-cycle pulse: set_vld hit a row already pending
- pend_cnt  out  LOG2N+1  number of pending rows

Behaviour:
- Reset (rst low at clk edge): pend vector = 0, state = IDLE, pend_cnt = 0, dup = 0. iss_vld is combinationally forced 0 while rst is low.
- Reset mid-handshake drops the offer; no clear is applied.
- pe_oht = pend register, direct.
- Set path: set_vld at edge t sets pend[set_idx] at t+1. Earliest iss_vld for that row is cycle t+1+PE_LAT.
- dup is registered and asserts at t+1 when pend[set_idx] was already 1. In that case pend_cnt is unchanged.
- Offer: iss_vld = (state==OFFER) & pe_vld & pend[pe_bin]; iss_idx = pe_bin. Both are combinational from inputs and state.
- Fire = iss_vld & iss_rdy. On fire, pend[iss_idx] is cleared at the next edge.
- iss_vld stays asserted with a stable iss_idx until fire, unless a higher-priority row becomes pending and the encoder output changes. Index changes while !iss_rdy are legal; the issuer samples only on fire.
- FSM:
  - IDLE: pend_cnt==0; go to OFFER when pend_cnt becomes nonzero.
  - OFFER: on fire, go to WAIT and load wcnt = PE_LAT.
  - WAIT: decrement wcnt; at 0, go to OFFER if pend_cnt != 0, else IDLE.
  - Throughput is one issue per PE_LAT+1 cycles.
- Simultaneous set and fire on the same row: set wins. The bit stays 1 and pend_cnt is unchanged; the row will be re-offered.
- Simultaneous set and fire on different rows: both apply, and pend_cnt is net unchanged.
- flush: all bits cleared and pend_cnt = 0 next cycle, then state goes to IDLE. flush has priority over a same-cycle set and fire. A fire in the flush cycle is still a completed transfer for the issuer.
- pend_cnt is maintained incrementally (+1 on a new set, -1 on a fire that is not re-set) and saturates at N.
- Stale guard: pend[pe_bin] gating guarantees a cleared row is never offered, even if PE_LAT is mis-set.

Optional Feature:
- Macro RFM_PEND_CNT_EN.
- Defined: pend_cnt counter and dup logic are present as described; IDLE↔OFFER uses pend_cnt.
- Undefined: pend_cnt is tied to 0 and dup to 0. The FSM uses (|pend) instead of pend_cnt, with no counter flops.
- Handshake behaviour is identical in both builds.

Decomposition:
- Shared package rfm_pkg holds:
  - constants RFM_N=1024 and RFM_LOG2N=10;
  - RFM_PE_LAT=1;
  - state encoding IDLE=2'd0, OFFER=2'd1, WAIT=2'd2.
- One natural sub-module, rfm_pend_vec: the N-bit set/clear/flush register plus the dup and count-delta outputs.
- The FSM and handshake stay in the top module.

Test Plan:
- Reset: rst low for 2 cycles with set_vld=1, set_idx=5 -> pe_oht=0, iss_vld=0, pend_cnt=0 throughout; after release, values are unchanged until the next set.
- Single row: set idx 700 at t, iss_rdy=1 -> pe_oht[700]=1 at t+1, iss_vld=1 with iss_idx=700 at t+2, bit cleared at t+3, pend_cnt 1→0, iss_vld=0 at t+3.
- Priority and back-pressure: set 3 and 900 with iss_rdy=0 for 4 cycles -> iss_idx=3 held steady. Raise iss_rdy -> 3 issues, then 900 exactly PE_LAT+1 cycles later.
- Collisions:
  - set 42 twice -> dup pulse on the second set, pend_cnt=1.
  - set 42 in the same cycle 42 fires -> bit stays 1, 42 re-offered after WAIT.
- Flush mid-offer: 10 rows pending, flush with iss_vld=1, iss_rdy=0 -> pend=0 and pend_cnt=0 next cycle, state IDLE, no iss_vld even though the stale pe_vld=1 lingers for PE_LAT.
- Build without RFM_PEND_CNT_EN: rerun scenarios 2 and 3 -> identical iss_* trace, pend_cnt=0 and dup=0 constant.
